// File: rtl/hazard_branch_unit.sv
// Decode-stage register hazard scoreboard with static branch prediction.
// Tracks in-flight writers, predicts the next PC and keeps return-PC history.
module hazard_branch_unit #(
    parameter int              NREGS      = 8,
    parameter int              HAZ_DEPTH  = 2,
    parameter int              HIST_DEPTH = 2,
    parameter int              PC_W       = 16,
    parameter logic [PC_W-1:0] RESET_PC   = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_valid,
    input  logic [NREGS-1:0] set_dec,
    input  logic [NREGS-1:0] dep_dec,
    input  logic             flush,
    input  logic [PC_W-1:0]  flush_pc,
    input  logic [PC_W-1:0]  pc_in,
    input  logic [2:0]       ir_msb3,
    input  logic [12:0]      ir_lsb13,
    input  logic [15:0]      psw_in,
    output logic [NREGS-1:0] stall,
    output logic             stall_any,
    output logic [PC_W-1:0]  pc_next,
    output logic [PC_W-1:0]  lbpc_lr,
    output logic [PC_W-1:0]  lbpc,
    output logic [15:0]      lbpsw
);

    logic [HAZ_DEPTH:1][NREGS-1:0] sb_q, sb_d;
    logic [HIST_DEPTH:1][PC_W-1:0] hist_q, hist_d;
    logic [PC_W-1:0]               pc_q, pc_d;
    logic [15:0]                   psw_q, psw_d;

    logic [NREGS-1:0]  pend;
    logic              advance;
    logic signed [12:0] disp13;
    logic signed [8:0]  disp9;
    logic [PC_W-1:0]   sext13;
    logic [PC_W-1:0]   sext9;
    logic [PC_W-1:0]   offset;
    logic [PC_W-1:0]   pc_plus2;

    always_comb begin
        pend = '0;
        for (int k = 1; k <= HAZ_DEPTH; k++) begin
            pend = pend | sb_q[k];
        end
    end

    // rst_n gating keeps stall quiet even before the async clear settles
    assign stall     = pend & dep_dec & {NREGS{dec_valid & rst_n}};
    assign stall_any = |stall;
    assign advance   = ~stall_any & ~flush;

    assign disp13   = ir_lsb13;
    assign disp9    = ir_lsb13[8:0];
    assign sext13   = PC_W'(disp13);
    assign sext9    = PC_W'(disp9);
    assign pc_plus2 = pc_in + PC_W'(2);

    always_comb begin
        offset = '0;
        unique case (1'b1)
            (ir_msb3 == 3'b000): offset = sext13 << 1;
            (ir_msb3 == 3'b001): offset = sext9 << 1;
            default:             offset = '0;
        endcase
    end

    always_comb begin
        sb_d    = '0;
        sb_d[1] = (dec_valid && advance) ? set_dec : '0;
        for (int k = 2; k <= HAZ_DEPTH; k++) begin
            sb_d[k] = sb_q[k-1];
        end

        pc_d   = pc_q;
        hist_d = hist_q;
        psw_d  = psw_q;
        if (flush) begin
            pc_d = flush_pc;
        end else if (advance) begin
            pc_d      = pc_plus2 + offset;
            hist_d[1] = pc_plus2;
            for (int k = 2; k <= HIST_DEPTH; k++) begin
                hist_d[k] = hist_q[k-1];
            end
            psw_d = psw_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q   <= '0;
            hist_q <= '0;
            pc_q   <= RESET_PC;
            psw_q  <= '0;
        end else begin
            sb_q   <= sb_d;
            hist_q <= hist_d;
            pc_q   <= pc_d;
            psw_q  <= psw_d;
        end
    end

    assign pc_next = pc_q;
    assign lbpc_lr = hist_q[1];
    assign lbpc    = hist_q[HIST_DEPTH];
    assign lbpsw   = psw_q;

endmodule

// File: tb/tb_hazard_branch_unit.sv
// Scoreboard bench for hazard_branch_unit (8 regs, depth 2, 16-bit PC).
// Expected state is predicted at drive time and popped after each edge.
module tb_hazard_branch_unit;

    localparam int          NR  = 8;
    localparam int          PW  = 16;
    localparam logic [15:0] RPC = 16'h0A00;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          dec_valid = 1'b0;
    logic [NR-1:0] set_dec = '0;
    logic [NR-1:0] dep_dec = '0;
    logic          flush = 1'b0;
    logic [PW-1:0] flush_pc = '0;
    logic [PW-1:0] pc_in = '0;
    logic [2:0]    ir_msb3 = 3'b010;
    logic [12:0]   ir_lsb13 = '0;
    logic [15:0]   psw_in = '0;
    logic [NR-1:0] stall;
    logic          stall_any;
    logic [PW-1:0] pc_next;
    logic [PW-1:0] lbpc_lr;
    logic [PW-1:0] lbpc;
    logic [15:0]   lbpsw;

    hazard_branch_unit #(
        .NREGS(NR), .HAZ_DEPTH(2), .HIST_DEPTH(2), .PC_W(PW), .RESET_PC(RPC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid),
        .set_dec(set_dec), .dep_dec(dep_dec), .flush(flush),
        .flush_pc(flush_pc), .pc_in(pc_in), .ir_msb3(ir_msb3),
        .ir_lsb13(ir_lsb13), .psw_in(psw_in), .stall(stall),
        .stall_any(stall_any), .pc_next(pc_next), .lbpc_lr(lbpc_lr),
        .lbpc(lbpc), .lbpsw(lbpsw)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] lr;
        logic [15:0] old;
        logic [15:0] psw;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    logic [15:0] m_pc, m_lr, m_old, m_psw;
    int          n_chk = 0;
    int          n_fail = 0;

    function automatic logic [15:0] offs(input logic [2:0] m, input logic [12:0] l);
        logic [15:0] v;
        case (m)
            3'b000:  v = {{3{l[12]}}, l};
            3'b001:  v = {{7{l[8]}}, l[8:0]};
            default: v = 16'h0000;
        endcase
        return {v[14:0], 1'b0};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_model;
        exp_t x;
        x.pc = m_pc; x.lr = m_lr; x.old = m_old; x.psw = m_psw;
        sbq.push_back(x);
    endtask

    task automatic expect_advance;
        m_old = m_lr;
        m_lr  = pc_in + 16'd2;
        m_pc  = pc_in + 16'd2 + offs(ir_msb3, ir_lsb13);
        m_psw = psw_in;
        push_model();
    endtask

    task automatic model_reset;
        m_pc = RPC; m_lr = '0; m_old = '0; m_psw = '0;
    endtask

    task automatic idle;
        dec_valid = 1'b0; set_dec = '0; dep_dec = '0;
        flush = 1'b0; ir_msb3 = 3'b010; ir_lsb13 = '0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            expect_advance();
            tick();
            e = sbq.pop_front();
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; dec_valid = 1'b1; dep_dec = 8'hFF; set_dec = 8'hFF;
        #1;
        n_chk++;
        if ({stall_any, stall} !== 9'h000) begin
            n_fail++;
            $display("FAIL reset_stall got %h want 000", {stall_any, stall});
        end
        tick();
        n_chk++;
        if ({pc_next, lbpc_lr, lbpc, lbpsw} !== {RPC, 48'h0}) begin
            n_fail++;
            $display("FAIL reset_state got %h want %h",
                     {pc_next, lbpc_lr, lbpc, lbpsw}, {RPC, 48'h0});
        end
        idle();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_branch_offset;
        logic [15:0] t_pc[8]  = '{16'h0100, 16'hFFFE, 16'hFFFE, 16'h1000,
                                  16'h1000, 16'h1000, 16'h2000, 16'h3000};
        logic [2:0]  t_m[8]   = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd0, 3'd1, 3'd7};
        logic [12:0] t_l[8]   = '{13'h1FFF, 13'h0001, 13'h0001, 13'h0FFF,
                                  13'h0100, 13'h1000, 13'h1E00, 13'h1FFF};
        logic [15:0] t_exp[8] = '{16'h0100, 16'h0002, 16'h0000, 16'h3000,
                                  16'h0E02, 16'hF002, 16'h2002, 16'h3002};
        for (int i = 0; i < 8; i++) begin
            pc_in = t_pc[i]; ir_msb3 = t_m[i]; ir_lsb13 = t_l[i];
            psw_in = 16'hA000 + 16'(i);
            expect_advance();
            tick();
            e = sbq.pop_front();
            n_chk++;
            if (pc_next !== t_exp[i]) begin
                n_fail++;
                $display("FAIL offset_pc[%0d] got %h want %h", i, pc_next, t_exp[i]);
            end
            n_chk++;
            if ({pc_next, lbpc_lr, lbpc, lbpsw} !== {e.pc, e.lr, e.old, e.psw}) begin
                n_fail++;
                $display("FAIL offset_state[%0d] got %h want %h", i,
                         {pc_next, lbpc_lr, lbpc, lbpsw}, {e.pc, e.lr, e.old, e.psw});
            end
        end
        n_chk++;
        if (lbpc_lr !== 16'h3002) begin
            n_fail++;
            $display("FAIL offset_lr got %h want 3002", lbpc_lr);
        end
    endtask

    task automatic test_back_to_back;
        idle();
        pc_in = 16'h0010; psw_in = 16'h0055;
        expect_advance();
        tick();
        e = sbq.pop_front();
        pc_in = 16'h0020; psw_in = 16'h0066;
        expect_advance();
        tick();
        e = sbq.pop_front();
        n_chk++;
        if ({lbpc_lr, lbpc, lbpsw} !== {16'h0022, 16'h0012, 16'h0066}) begin
            n_fail++;
            $display("FAIL b2b_history got %h want 0022_0012_0066",
                     {lbpc_lr, lbpc, lbpsw});
        end
        n_chk++;
        if ({pc_next, lbpc_lr, lbpc, lbpsw} !== {e.pc, e.lr, e.old, e.psw}) begin
            n_fail++;
            $display("FAIL b2b_state got %h want %h",
                     {pc_next, lbpc_lr, lbpc, lbpsw}, {e.pc, e.lr, e.old, e.psw});
        end
    endtask

    task automatic test_stall;
        idle();
        drain(2);
        dec_valid = 1'b1; set_dec = 8'h04; dep_dec = 8'h00;
        pc_in = 16'h0400; psw_in = 16'h0400;
        #1;
        n_chk++;
        if (stall !== 8'h00) begin
            n_fail++;
            $display("FAIL stall_producer got %h want 00", stall);
        end
        expect_advance();
        tick();
        e = sbq.pop_front();
        set_dec = 8'h08; dep_dec = 8'h0C; pc_in = 16'h0402; psw_in = 16'h0402;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_chk++;
            if ({stall_any, stall} !== 9'h104) begin
                n_fail++;
                $display("FAIL stall_cycle[%0d] got %h want 104", c, {stall_any, stall});
            end
            push_model();
            tick();
            e = sbq.pop_front();
            n_chk++;
            if ({pc_next, lbpc_lr, lbpc, lbpsw} !== {e.pc, e.lr, e.old, e.psw}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d] got %h want %h", c,
                         {pc_next, lbpc_lr, lbpc, lbpsw}, {e.pc, e.lr, e.old, e.psw});
            end
        end
        #1;
        n_chk++;
        if ({stall_any, stall} !== 9'h000) begin
            n_fail++;
            $display("FAIL stall_release got %h want 000", {stall_any, stall});
        end
        expect_advance();
        tick();
        e = sbq.pop_front();
        n_chk++;
        if ({pc_next, lbpc_lr, lbpc, lbpsw} !== {e.pc, e.lr, e.old, e.psw}) begin
            n_fail++;
            $display("FAIL stall_retry_adv got %h want %h",
                     {pc_next, lbpc_lr, lbpc, lbpsw}, {e.pc, e.lr, e.old, e.psw});
        end
        set_dec = 8'h00; dep_dec = 8'h08; pc_in = 16'h0404;
        #1;
        n_chk++;
        if (stall !== 8'h08) begin
            n_fail++;
            $display("FAIL stall_consumer_tracked got %h want 08", stall);
        end
        dec_valid = 1'b0;
        #1;
        n_chk++;
        if ({stall_any, stall} !== 9'h000) begin
            n_fail++;
            $display("FAIL stall_invalid got %h want 000", {stall_any, stall});
        end
        idle();
        drain(2);
    endtask

    task automatic test_flush;
        idle();
        dec_valid = 1'b1; set_dec = 8'h10; pc_in = 16'h0500; psw_in = 16'h1111;
        expect_advance();
        tick();
        e = sbq.pop_front();
        set_dec = 8'h20; dep_dec = 8'h10; pc_in = 16'h0502; psw_in = 16'h2222;
        #1;
        n_chk++;
        if (stall !== 8'h10) begin
            n_fail++;
            $display("FAIL flush_pre_stall got %h want 10", stall);
        end
        flush = 1'b1; flush_pc = 16'h0200;
        m_pc = 16'h0200;
        push_model();
        tick();
        e = sbq.pop_front();
        n_chk++;
        if ({pc_next, lbpc_lr, lbpc, lbpsw} !== {16'h0200, e.lr, e.old, 16'h1111}) begin
            n_fail++;
            $display("FAIL flush_state got %h want %h",
                     {pc_next, lbpc_lr, lbpc, lbpsw}, {16'h0200, e.lr, e.old, 16'h1111});
        end
        flush = 1'b0; set_dec = 8'h00; dep_dec = 8'h30;
        #1;
        n_chk++;
        if (stall !== 8'h10) begin
            n_fail++;
            $display("FAIL flush_bubble got %h want 10", stall);
        end
        idle();
        drain(2);
    endtask

    task automatic test_reset_mid_stall;
        idle();
        dec_valid = 1'b1; set_dec = 8'h01; pc_in = 16'h0700; psw_in = 16'h7777;
        expect_advance();
        tick();
        e = sbq.pop_front();
        set_dec = 8'h00; dep_dec = 8'h01;
        #1;
        n_chk++;
        if (stall !== 8'h01) begin
            n_fail++;
            $display("FAIL rst_pre_stall got %h want 01", stall);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({stall_any, stall, pc_next, lbpc_lr} !== {9'h000, RPC, 16'h0000}) begin
            n_fail++;
            $display("FAIL rst_async got %h want %h",
                     {stall_any, stall, pc_next, lbpc_lr}, {9'h000, RPC, 16'h0000});
        end
        #2;
        rst_n = 1'b1;
        model_reset();
        #1;
        n_chk++;
        if (stall !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_released_stall got %h want 00", stall);
        end
        expect_advance();
        tick();
        e = sbq.pop_front();
        n_chk++;
        if ({stall_any, pc_next, lbpc_lr, lbpc, lbpsw} !==
            {1'b0, e.pc, e.lr, e.old, e.psw}) begin
            n_fail++;
            $display("FAIL rst_after_adv got %h want %h",
                     {stall_any, pc_next, lbpc_lr, lbpc, lbpsw},
                     {1'b0, e.pc, e.lr, e.old, e.psw});
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_branch_offset();
        test_back_to_back();
        test_stall();
        test_flush();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
